uart_frame_checker: RTL and testbench
=====================================

// Module: uart_frame_checker
// PURPOSE
//   Registered, parametrised frame checker for the UART receive path. It sits between
//   the bit-sampling receiver and the RX FIFO/host interface.
//   Per received frame it checks start, stop(s) and parity (five modes) and detects break.
//   Result is held in a one-entry valid/ready output stage; overrun is flagged when it is still full.
//   Saturating per-error statistics counters are provided.
// PARAMETERS
//   DATA_W  8  data bits per frame, legal 5..9
//   CNT_W   8  width of each statistics counter, legal 4..16
// PORTS
//   clk              in   1       clock, all logic rising-edge
//   rst_n            in   1       asynchronous active-low reset
//   frame_valid      in   1       1-cycle pulse: frame fields below valid this cycle
//   frame_data       in   DATA_W  received data bits, LSB = first on line
//   start_bit        in   1       sampled start bit
//   stop_bits        in   2       sampled stop bits; [0] first stop, [1] second stop
//   parity_bit       in   1       sampled parity bit (ignored when parity_type = NONE)
//   parity_type      in   3       000 NONE, 001 ODD, 010 EVEN, 011 MARK, 100 SPACE, others reserved
//   two_stop         in   1       1 = check both stop bits, 0 = check stop_bits[0] only
//   status_ready     in   1       downstream accepts status this cycle
//   clr_counts       in   1       synchronous clear of all counters
//   status_valid     out  1       status_data/err_flag hold a checked frame
//   status_data      out  DATA_W  data of the held frame
//   err_flag         out  4       {break, stop_err, start_err, parity_err}; 1 = error
//   overrun          out  1       sticky: frame lost because output stage was full
//   frame_cnt        out  CNT_W   frames accepted into output stage
//   parity_err_cnt   out  CNT_W   accepted frames with parity_err
//   framing_err_cnt  out  CNT_W   accepted frames with start_err or stop_err
//   overrun_cnt      out  CNT_W   frames dropped due to overrun
// BEHAVIOUR
//   Reset: all outputs 0, output stage empty.
//   Check logic (combinational on frame fields; all checks use parity_type/two_stop sampled with frame_valid):
//     start_err = start_bit; stop_err = ~stop_bits[0] | (two_stop & ~stop_bits[1]).
//     ODD: parity_err = ~(^frame_data ^ parity_bit).
//     EVEN: parity_err = ^frame_data ^ parity_bit.
//     MARK: parity_err = ~parity_bit; SPACE: parity_err = parity_bit; NONE: 0.
//     Reserved parity_type: parity_err = 1.
//     break = start_bit==0 & frame_data==0 & stop_bits[0]==0 & (parity_bit==0 or NONE); stop_err still set.
//   Output stage, one entry, latency 1: frame_valid in cycle N -> status_valid in N+1.
//     Handshake: transfer when status_valid & status_ready; data/flags stable while valid & ~ready.
//     frame_valid while stage empty, or full with status_ready same cycle: load new frame, valid stays/goes 1.
//     frame_valid while full & ~status_ready: frame dropped; stage unchanged; overrun <= 1, overrun_cnt++.
//     status_valid & status_ready without frame_valid: stage empties next cycle.
//   overrun clears only on reset or clr_counts.
//   Counters: increment on load (frame_cnt always, error counters per flags), saturate at 2^CNT_W-1.
//     clr_counts clears counters and overrun; clr_counts + increment in same cycle -> result 0.
//   Reset mid-frame: stage emptied immediately; a frame_valid during reset is lost, not counted.
// TESTING
//   EVEN, DATA_W=8, data 8'hA5, parity 0, start 0, stop 01 -> next cycle valid, err_flag 4'b0000, frame_cnt 1.
//   ODD, data 8'h01, parity 1 -> parity_err 1, parity_err_cnt 1.
//     MARK parity 0 -> parity_err 1.
//     type 3'b111 -> parity_err 1.
//   two_stop=1, stop_bits 2'b01 -> stop_err 1; data 0, start 0, stop 00, NONE -> err_flag 4'b1100.
//   status_ready=0, two frame_valid pulses (8'h11 then 8'h22) -> status_data stays 8'h11, overrun 1, overrun_cnt 1.
//     Then status_ready=1 with frame 8'h33 same cycle -> 8'h33 loaded, no overrun_cnt change.
//   CNT_W=4: 20 frames with parity errors -> parity_err_cnt holds 15.
//     clr_counts together with a frame -> all counters 0, overrun 0.
//   Assert rst_n low while status_valid=1 -> all outputs 0 asynchronously; first frame after release latency 1.

Source files
------------

// File: rtl/uart_frame_checker.sv
// ============================================================================
// uart_frame_checker
//
// Purpose
//   Frame checker for the UART receive path, placed between the bit-sampling
//   receiver and the RX FIFO / host interface. For every frame presented on
//   frame_valid it checks the start bit, the stop bit(s) and the parity bit,
//   and it detects a line break. Each checked frame goes into a one-entry
//   valid/ready output stage with a latency of one cycle. When a frame
//   arrives while that stage is full and not being drained, the frame is
//   dropped and the sticky overrun flag is raised. Saturating statistics
//   counters track accepted frames, parity errors, framing errors and
//   dropped frames.
//
// Parameters
//   DATA_W  data bits per frame (5..9)
//   CNT_W   width of each statistics counter (4..16)
//
// Ports
//   clk              in   clock, all logic on the rising edge
//   rst_n            in   asynchronous active-low reset
//   frame_valid      in   one-cycle pulse, frame fields valid this cycle
//   frame_data       in   received data bits, LSB first on the line
//   start_bit        in   sampled start bit
//   stop_bits        in   sampled stop bits, [0] first, [1] second
//   parity_bit       in   sampled parity bit
//   parity_type      in   000 NONE, 001 ODD, 010 EVEN, 011 MARK, 100 SPACE
//   two_stop         in   1 = check both stop bits
//   status_ready     in   downstream accepts the held status this cycle
//   clr_counts       in   synchronous clear of counters and overrun
//   status_valid     out  output stage holds a checked frame
//   status_data      out  data of the held frame
//   err_flag         out  {break, stop_err, start_err, parity_err}
//   overrun          out  sticky: a frame was lost to a full output stage
//   frame_cnt        out  frames accepted into the output stage
//   parity_err_cnt   out  accepted frames with a parity error
//   framing_err_cnt  out  accepted frames with a start or stop error
//   overrun_cnt      out  frames dropped because of overrun
// ============================================================================
module uart_frame_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_valid,
    input  logic [DATA_W-1:0] frame_data,
    input  logic              start_bit,
    input  logic [1:0]        stop_bits,
    input  logic              parity_bit,
    input  logic [2:0]        parity_type,
    input  logic              two_stop,
    input  logic              status_ready,
    input  logic              clr_counts,
    output logic              status_valid,
    output logic [DATA_W-1:0] status_data,
    output logic [3:0]        err_flag,
    output logic              overrun,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  parity_err_cnt,
    output logic [CNT_W-1:0]  framing_err_cnt,
    output logic [CNT_W-1:0]  overrun_cnt
);

    localparam logic [2:0] PAR_NONE  = 3'b000;
    localparam logic [2:0] PAR_ODD   = 3'b001;
    localparam logic [2:0] PAR_EVEN  = 3'b010;
    localparam logic [2:0] PAR_MARK  = 3'b011;
    localparam logic [2:0] PAR_SPACE = 3'b100;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counter step that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             en);
        if (en && (cnt != CNT_MAX)) begin
            return cnt + CNT_ONE;
        end
        return cnt;
    endfunction

    // Parity check. A reserved parity_type is reported as a parity error so
    // that a misconfigured receiver cannot silently pass frames through.
    function automatic logic calc_parity_err(input logic [DATA_W-1:0] data,
                                             input logic              par,
                                             input logic [2:0]        ptype);
        logic data_odd;
        data_odd = ^data;
        case (ptype)
            PAR_NONE:  return 1'b0;
            PAR_ODD:   return ~(data_odd ^ par);
            PAR_EVEN:  return data_odd ^ par;
            PAR_MARK:  return ~par;
            PAR_SPACE: return par;
            default:   return 1'b1;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              status_valid_q,    status_valid_d;
    logic [DATA_W-1:0] status_data_q,     status_data_d;
    logic [3:0]        err_flag_q,        err_flag_d;
    logic              overrun_q,         overrun_d;
    logic [CNT_W-1:0]  frame_cnt_q,       frame_cnt_d;
    logic [CNT_W-1:0]  parity_err_cnt_q,  parity_err_cnt_d;
    logic [CNT_W-1:0]  framing_err_cnt_q, framing_err_cnt_d;
    logic [CNT_W-1:0]  overrun_cnt_q,     overrun_cnt_d;

    // ------------------------------------------------------------------
    // Frame checks (combinational on the incoming frame fields)
    // ------------------------------------------------------------------
    logic       start_err;
    logic       stop_err;
    logic       parity_err;
    logic       break_det;
    logic [3:0] frame_flags;
    logic       load;
    logic       drop;
    logic       drain;

    always_comb begin
        start_err  = start_bit;
        stop_err   = ~stop_bits[0] | (two_stop & ~stop_bits[1]);
        parity_err = calc_parity_err(frame_data, parity_bit, parity_type);
        // A break holds the line low for the whole frame; with no parity
        // bit configured the sampled parity_bit carries no information.
        break_det  = ~start_bit & (frame_data == '0) & ~stop_bits[0] &
                     (~parity_bit | (parity_type == PAR_NONE));
        frame_flags = {break_det, stop_err, start_err, parity_err};

        drain = status_valid_q & status_ready;
        // A frame may enter when the stage is empty or is being drained in
        // the same cycle; otherwise it is lost.
        load  = frame_valid & (~status_valid_q | status_ready);
        drop  = frame_valid & status_valid_q & ~status_ready;
    end

    // ------------------------------------------------------------------
    // Next-state logic: output stage, overrun flag, statistics
    // ------------------------------------------------------------------
    always_comb begin
        status_valid_d    = status_valid_q;
        status_data_d     = status_data_q;
        err_flag_d        = err_flag_q;
        overrun_d         = overrun_q;
        frame_cnt_d       = frame_cnt_q;
        parity_err_cnt_d  = parity_err_cnt_q;
        framing_err_cnt_d = framing_err_cnt_q;
        overrun_cnt_d     = overrun_cnt_q;

        if (load) begin
            status_valid_d = 1'b1;
            status_data_d  = frame_data;
            err_flag_d     = frame_flags;
        end else if (drain) begin
            // Data and flags are left in place; only valid drops.
            status_valid_d = 1'b0;
        end

        // Clearing wins over any increment arriving in the same cycle.
        if (clr_counts) begin
            overrun_d         = 1'b0;
            frame_cnt_d       = '0;
            parity_err_cnt_d  = '0;
            framing_err_cnt_d = '0;
            overrun_cnt_d     = '0;
        end else begin
            overrun_d         = overrun_q | drop;
            frame_cnt_d       = sat_inc(frame_cnt_q, load);
            parity_err_cnt_d  = sat_inc(parity_err_cnt_q, load & parity_err);
            framing_err_cnt_d = sat_inc(framing_err_cnt_q,
                                        load & (start_err | stop_err));
            overrun_cnt_d     = sat_inc(overrun_cnt_q, drop);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_valid_q    <= 1'b0;
            status_data_q     <= '0;
            err_flag_q        <= '0;
            overrun_q         <= 1'b0;
            frame_cnt_q       <= '0;
            parity_err_cnt_q  <= '0;
            framing_err_cnt_q <= '0;
            overrun_cnt_q     <= '0;
        end else begin
            status_valid_q    <= status_valid_d;
            status_data_q     <= status_data_d;
            err_flag_q        <= err_flag_d;
            overrun_q         <= overrun_d;
            frame_cnt_q       <= frame_cnt_d;
            parity_err_cnt_q  <= parity_err_cnt_d;
            framing_err_cnt_q <= framing_err_cnt_d;
            overrun_cnt_q     <= overrun_cnt_d;
        end
    end

    assign status_valid    = status_valid_q;
    assign status_data     = status_data_q;
    assign err_flag        = err_flag_q;
    assign overrun         = overrun_q;
    assign frame_cnt       = frame_cnt_q;
    assign parity_err_cnt  = parity_err_cnt_q;
    assign framing_err_cnt = framing_err_cnt_q;
    assign overrun_cnt     = overrun_cnt_q;

endmodule

// File: tb/tb_uart_frame_checker.sv
// ============================================================================
// tb_uart_frame_checker
//
// Directed bench for uart_frame_checker (DATA_W=8, CNT_W=4). A behavioural
// model derives the expected status from the frame rules (bit counting,
// saturating integer counters) and is compared against the DUT on every
// falling clock edge; literal expectations at key points pin the model.
// ============================================================================
module tb_uart_frame_checker;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_valid = 1'b0;
    logic [DATA_W-1:0] frame_data = '0;
    logic              start_bit = 1'b0;
    logic [1:0]        stop_bits = 2'b01;
    logic              parity_bit = 1'b0;
    logic [2:0]        parity_type = 3'b000;
    logic              two_stop = 1'b0;
    logic              status_ready = 1'b1;
    logic              clr_counts = 1'b0;
    logic              status_valid;
    logic [DATA_W-1:0] status_data;
    logic [3:0]        err_flag;
    logic              overrun;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  parity_err_cnt;
    logic [CNT_W-1:0]  framing_err_cnt;
    logic [CNT_W-1:0]  overrun_cnt;

    uart_frame_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_valid     (frame_valid),
        .frame_data      (frame_data),
        .start_bit       (start_bit),
        .stop_bits       (stop_bits),
        .parity_bit      (parity_bit),
        .parity_type     (parity_type),
        .two_stop        (two_stop),
        .status_ready    (status_ready),
        .clr_counts      (clr_counts),
        .status_valid    (status_valid),
        .status_data     (status_data),
        .err_flag        (err_flag),
        .overrun         (overrun),
        .frame_cnt       (frame_cnt),
        .parity_err_cnt  (parity_err_cnt),
        .framing_err_cnt (framing_err_cnt),
        .overrun_cnt     (overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [3:0] model_flags(input logic [7:0] d, input logic s,
                                               input logic [1:0] st, input logic p,
                                               input logic [2:0] pt, input logic two);
        int   ones;
        logic pe, se, be;
        ones = $countones(d) + (p ? 1 : 0);
        case (pt)
            3'd0:    pe = 1'b0;
            3'd1:    pe = ((ones % 2) == 0);   // odd total required
            3'd2:    pe = ((ones % 2) == 1);   // even total required
            3'd3:    pe = (p == 1'b0);
            3'd4:    pe = (p == 1'b1);
            default: pe = 1'b1;
        endcase
        se = (st[0] == 1'b0) || (two && (st[1] == 1'b0));
        be = (s == 1'b0) && (d == 8'd0) && (st[0] == 1'b0) && ((p == 1'b0) || (pt == 3'd0));
        return {be, se, s, pe};
    endfunction

    bit         m_valid = 1'b0;
    logic [7:0] m_data  = '0;
    logic [3:0] m_flags = '0;
    bit         m_ovr   = 1'b0;
    int         m_fc = 0, m_pc = 0, m_fec = 0, m_oc = 0;

    logic [3:0] in_flags;
    bit         in_load, in_drop;

    always_comb begin
        in_flags = model_flags(frame_data, start_bit, stop_bits, parity_bit, parity_type, two_stop);
        in_load  = frame_valid && (!m_valid || status_ready);
        in_drop  = frame_valid && m_valid && !status_ready;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_data <= '0; m_flags <= '0; m_ovr <= 1'b0;
            m_fc <= 0; m_pc <= 0; m_fec <= 0; m_oc <= 0;
        end else begin
            if (in_load) begin
                m_valid <= 1'b1; m_data <= frame_data; m_flags <= in_flags;
            end else if (m_valid && status_ready) begin
                m_valid <= 1'b0;
            end
            if (clr_counts) begin
                m_ovr <= 1'b0; m_fc <= 0; m_pc <= 0; m_fec <= 0; m_oc <= 0;
            end else begin
                if (in_drop) m_ovr <= 1'b1;
                if (in_load && m_fc < CMAX) m_fc <= m_fc + 1;
                if (in_load && in_flags[0] && m_pc < CMAX) m_pc <= m_pc + 1;
                if (in_load && (in_flags[1] || in_flags[2]) && m_fec < CMAX) m_fec <= m_fec + 1;
                if (in_drop && m_oc < CMAX) m_oc <= m_oc + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("mdl_status_valid", 32'(status_valid), 32'(m_valid));
            if (m_valid) begin
                check("mdl_status_data", 32'(status_data), 32'(m_data));
                check("mdl_err_flag", 32'(err_flag), 32'(m_flags));
            end
            check("mdl_overrun", 32'(overrun), 32'(m_ovr));
            check("mdl_frame_cnt", 32'(frame_cnt), m_fc);
            check("mdl_parity_err_cnt", 32'(parity_err_cnt), m_pc);
            check("mdl_framing_err_cnt", 32'(framing_err_cnt), m_fec);
            check("mdl_overrun_cnt", 32'(overrun_cnt), m_oc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] d, input logic s, input logic [1:0] st,
                        input logic p, input logic [2:0] pt, input logic two);
        frame_data  = d;
        start_bit   = s;
        stop_bits   = st;
        parity_bit  = p;
        parity_type = pt;
        two_stop    = two;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_status_valid", 32'(status_valid), 32'(1'b0));
        check("rst_err_flag", 32'(err_flag), 32'(4'b0000));
        check("rst_overrun", 32'(overrun), 32'(1'b0));
        check("rst_frame_cnt", 32'(frame_cnt), 32'(4'd0));
        rst_n = 1'b1;
        @(negedge clk);

        // EVEN, A5 (four ones) with parity 0: clean frame, visible next cycle
        send(8'hA5, 1'b0, 2'b01, 1'b0, 3'b010, 1'b0);
        check("even_valid", 32'(status_valid), 32'(1'b1));
        check("even_data", 32'(status_data), 32'(8'hA5));
        check("even_err", 32'(err_flag), 32'(4'b0000));
        check("even_frame_cnt", 32'(frame_cnt), 32'(4'd1));

        send(8'h01, 1'b0, 2'b01, 1'b1, 3'b001, 1'b0);       // ODD, total ones even
        check("odd_err", 32'(err_flag), 32'(4'b0001));
        check("odd_parity_cnt", 32'(parity_err_cnt), 32'(4'd1));

        send(8'h3C, 1'b0, 2'b01, 1'b0, 3'b011, 1'b0);       // MARK with 0
        check("mark_err", 32'(err_flag), 32'(4'b0001));

        send(8'h3C, 1'b0, 2'b01, 1'b1, 3'b111, 1'b0);       // reserved type
        check("rsvd_err", 32'(err_flag), 32'(4'b0001));
        check("rsvd_parity_cnt", 32'(parity_err_cnt), 32'(4'd3));

        send(8'h3C, 1'b0, 2'b01, 1'b0, 3'b100, 1'b0);       // SPACE with 0
        check("space_err", 32'(err_flag), 32'(4'b0000));

        send(8'h55, 1'b0, 2'b01, 1'b0, 3'b000, 1'b1);       // second stop low
        check("stop2_err", 32'(err_flag), 32'(4'b0100));

        send(8'h00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0);       // break
        check("break_err", 32'(err_flag), 32'(4'b1100));

        send(8'h12, 1'b1, 2'b01, 1'b0, 3'b000, 1'b0);       // start bit high
        check("start_err", 32'(err_flag), 32'(4'b0010));
        check("framing_cnt", 32'(framing_err_cnt), 32'(4'd3));
        check("frame_cnt_8", 32'(frame_cnt), 32'(4'd8));

        // Overrun: stage full and not drained
        @(negedge clk);
        status_ready = 1'b0;
        send(8'h11, 1'b0, 2'b01, 1'b0, 3'b010, 1'b0);
        send(8'h22, 1'b0, 2'b01, 1'b0, 3'b010, 1'b0);
        check("ovr_data_held", 32'(status_data), 32'(8'h11));
        check("ovr_flag", 32'(overrun), 32'(1'b1));
        check("ovr_cnt", 32'(overrun_cnt), 32'(4'd1));
        @(negedge clk);
        check("ovr_hold_data", 32'(status_data), 32'(8'h11));
        status_ready = 1'b1;
        send(8'h33, 1'b0, 2'b01, 1'b0, 3'b010, 1'b0);       // drain + load together
        check("swap_data", 32'(status_data), 32'(8'h33));
        check("swap_valid", 32'(status_valid), 32'(1'b1));
        check("swap_ovr_cnt", 32'(overrun_cnt), 32'(4'd1));
        @(negedge clk);
        check("drain_valid", 32'(status_valid), 32'(1'b0));

        // Saturation
        for (int i = 0; i < 20; i++) send(8'h01, 1'b0, 2'b01, 1'b1, 3'b001, 1'b0);
        check("sat_parity_cnt", 32'(parity_err_cnt), 32'(4'd15));
        check("sat_frame_cnt", 32'(frame_cnt), 32'(4'd15));
        check("sat_overrun_sticky", 32'(overrun), 32'(1'b1));

        // Clear together with an incoming frame
        clr_counts = 1'b1;
        send(8'h01, 1'b1, 2'b00, 1'b1, 3'b001, 1'b0);
        clr_counts = 1'b0;
        check("clr_frame_cnt", 32'(frame_cnt), 32'(4'd0));
        check("clr_parity_cnt", 32'(parity_err_cnt), 32'(4'd0));
        check("clr_framing_cnt", 32'(framing_err_cnt), 32'(4'd0));
        check("clr_overrun_cnt", 32'(overrun_cnt), 32'(4'd0));
        check("clr_overrun", 32'(overrun), 32'(1'b0));
        check("clr_frame_loaded", 32'(status_valid), 32'(1'b1));

        // Asynchronous reset while the stage is full
        status_ready = 1'b0;
        send(8'h5A, 1'b0, 2'b01, 1'b0, 3'b010, 1'b0);
        check("prerst_valid", 32'(status_valid), 32'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(status_valid), 32'(1'b0));
        check("arst_data", 32'(status_data), 32'(8'h00));
        check("arst_err", 32'(err_flag), 32'(4'b0000));
        check("arst_frame_cnt", 32'(frame_cnt), 32'(4'd0));
        @(negedge clk);
        send(8'h77, 1'b0, 2'b01, 1'b0, 3'b010, 1'b0);       // lost during reset
        check("inrst_valid", 32'(status_valid), 32'(1'b0));
        rst_n = 1'b1;
        status_ready = 1'b1;
        send(8'h0F, 1'b0, 2'b01, 1'b0, 3'b010, 1'b0);
        check("post_rst_valid", 32'(status_valid), 32'(1'b1));
        check("post_rst_data", 32'(status_data), 32'(8'h0F));
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'(4'd1));
        repeat (2) @(negedge clk);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
